// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file issue/writeback controller.
package regfile_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NREGS = 2 ** AW;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xdata_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic {
    WB_ALU,
    WB_LD
  } wb_src_e;

  // One-hot mask for a register address.
  function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t addr);
    logic [NREGS-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_issue_ctrl_if.sv
// Issue, operand, writeback and register-file port bundle for regfile_issue_ctrl.
// slave: the controller. master: the surrounding pipeline and register file.
interface regfile_issue_ctrl_if;
  import regfile_pkg::*;

  logic      iss_valid;
  logic      iss_ready;
  reg_addr_t iss_rs1;
  reg_addr_t iss_rs2;
  reg_addr_t iss_rd;
  logic      iss_rd_we;

  logic      op_valid;
  xdata_t    op_rs1_data;
  xdata_t    op_rs2_data;

  logic      alu_wb_valid;
  reg_addr_t alu_wb_addr;
  xdata_t    alu_wb_data;

  logic      ld_wb_valid;
  logic      ld_wb_ready;
  reg_addr_t ld_wb_addr;
  xdata_t    ld_wb_data;

  logic      rs1_read;
  logic      rs2_read;
  reg_addr_t rs1_addr;
  reg_addr_t rs2_addr;
  xdata_t    rs1_rdata;
  xdata_t    rs2_rdata;

  logic      rd_write;
  reg_addr_t rd_addr;
  xdata_t    rd_wdata;

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    output iss_ready,
    output op_valid, op_rs1_data, op_rs2_data,
    input  alu_wb_valid, alu_wb_addr, alu_wb_data,
    input  ld_wb_valid, ld_wb_addr, ld_wb_data,
    output ld_wb_ready,
    output rs1_read, rs2_read, rs1_addr, rs2_addr,
    input  rs1_rdata, rs2_rdata,
    output rd_write, rd_addr, rd_wdata
  );

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_we,
    input  iss_ready,
    input  op_valid, op_rs1_data, op_rs2_data,
    output alu_wb_valid, alu_wb_addr, alu_wb_data,
    output ld_wb_valid, ld_wb_addr, ld_wb_data,
    input  ld_wb_ready,
    input  rs1_read, rs2_read, rs1_addr, rs2_addr,
    output rs1_rdata, rs2_rdata,
    input  rd_write, rd_addr, rd_wdata
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bits, RAW/WAW hazard check, sticky writeback error.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  // Release: accepted nonzero writeback this cycle
  input  logic             rel_valid,
  input  reg_addr_t        rel_addr,
  // Issue candidate
  input  reg_addr_t        chk_rs1,
  input  reg_addr_t        chk_rs2,
  input  reg_addr_t        chk_rd,
  input  logic             chk_rd_we,
  input  logic             iss_accept,
  output logic             hazard,
  output logic [NREGS-1:0] busy,
  output logic             wb_err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             wb_err_q, wb_err_d;
  logic             set_valid;

  // A register blocks only if pending and not being released this very cycle.
  function automatic logic blocks(input reg_addr_t r, input logic [NREGS-1:0] bsy,
                                  input logic rv, input reg_addr_t ra);
    return (r != REG_ZERO) && bsy[r] && !(rv && (ra == r));
  endfunction

  // Hazard detection and next-state for busy bits and error flag.
  always_comb begin
    hazard = blocks(chk_rs1, busy_q, rel_valid, rel_addr) ||
             blocks(chk_rs2, busy_q, rel_valid, rel_addr) ||
             (chk_rd_we && blocks(chk_rd, busy_q, rel_valid, rel_addr));

    set_valid = iss_accept && chk_rd_we && (chk_rd != REG_ZERO);

    busy_d = busy_q;
    if (rel_valid) busy_d = busy_d & ~reg_onehot(rel_addr);
    // Set after clear so release-and-reissue of the same register stays pending.
    if (set_valid) busy_d = busy_d | reg_onehot(chk_rd);

    wb_err_d = wb_err_q;
    if (rel_valid && !busy_q[rel_addr]) wb_err_d = 1'b1;
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  assign busy   = busy_q;
  assign wb_err = wb_err_q;

endmodule

// File: rtl/regfile_issue_ctrl.sv
// Issue/writeback controller for a 2R/1W 16x32 register file with x0 hardwired to zero.
module regfile_issue_ctrl
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_issue_ctrl_if.slave  bus,
  output logic [NREGS-1:0]     busy,
  output logic                 wb_err
);

  wb_src_e   wb_src;
  logic      wb_valid;
  reg_addr_t wb_addr;
  xdata_t    wb_data;
  logic      hazard;
  logic      iss_accept;

  logic   rs1_use_rf_q, rs1_use_rf_d;
  logic   rs2_use_rf_q, rs2_use_rf_d;
  xdata_t rs1_data_q, rs1_data_d;
  xdata_t rs2_data_q, rs2_data_d;
  logic   op_valid_q;

  // Write-port arbitration: ALU has priority, load unit waits.
  always_comb begin
    wb_src   = bus.alu_wb_valid ? WB_ALU : WB_LD;
    wb_valid = bus.alu_wb_valid || bus.ld_wb_valid;
    wb_addr  = (wb_src == WB_ALU) ? bus.alu_wb_addr : bus.ld_wb_addr;
    wb_data  = (wb_src == WB_ALU) ? bus.alu_wb_data : bus.ld_wb_data;

    bus.ld_wb_ready = !bus.alu_wb_valid;
    bus.rd_write    = wb_valid && (wb_addr != REG_ZERO);
    bus.rd_addr     = wb_addr;
    bus.rd_wdata    = wb_data;
  end

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .rel_valid  (bus.rd_write),
    .rel_addr   (wb_addr),
    .chk_rs1    (bus.iss_rs1),
    .chk_rs2    (bus.iss_rs2),
    .chk_rd     (bus.iss_rd),
    .chk_rd_we  (bus.iss_rd_we),
    .iss_accept (iss_accept),
    .hazard     (hazard),
    .busy       (busy),
    .wb_err     (wb_err)
  );

  // Issue handshake, read-lane drive and per-lane operand source selection.
  always_comb begin
    bus.iss_ready = !hazard;
    iss_accept    = bus.iss_valid && !hazard;
    bus.rs1_read  = iss_accept;
    bus.rs2_read  = iss_accept;
    bus.rs1_addr  = bus.iss_rs1;
    bus.rs2_addr  = bus.iss_rs2;

    rs1_use_rf_d = 1'b0;
    rs1_data_d   = '0;
    if (bus.iss_rs1 != REG_ZERO) begin
      // The register file returns pre-write data, so a same-cycle write is forwarded.
      if (bus.rd_write && (wb_addr == bus.iss_rs1)) rs1_data_d = wb_data;
      else rs1_use_rf_d = 1'b1;
    end

    rs2_use_rf_d = 1'b0;
    rs2_data_d   = '0;
    if (bus.iss_rs2 != REG_ZERO) begin
      if (bus.rd_write && (wb_addr == bus.iss_rs2)) rs2_data_d = wb_data;
      else rs2_use_rf_d = 1'b1;
    end
  end

  // Operand stage registers, loaded on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid_q   <= 1'b0;
      rs1_use_rf_q <= 1'b0;
      rs2_use_rf_q <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
    end else begin
      op_valid_q <= iss_accept;
      if (iss_accept) begin
        rs1_use_rf_q <= rs1_use_rf_d;
        rs2_use_rf_q <= rs2_use_rf_d;
        rs1_data_q   <= rs1_data_d;
        rs2_data_q   <= rs2_data_d;
      end
    end
  end

  // Operand output mux: register-file data or captured zero/forwarded value.
  always_comb begin
    bus.op_valid    = op_valid_q;
    bus.op_rs1_data = rs1_use_rf_q ? bus.rs1_rdata : rs1_data_q;
    bus.op_rs2_data = rs2_use_rf_q ? bus.rs2_rdata : rs2_data_q;
  end

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Directed bench for regfile_issue_ctrl with a behavioural 16x32 register file.
module tb_regfile_issue_ctrl;
  import regfile_pkg::*;

  logic             clk;
  logic             rst;
  logic [NREGS-1:0] busy;
  logic             wb_err;
  xdata_t           mem [NREGS];

  int vectors;
  int miscompares;

  regfile_issue_ctrl_if bus ();

  regfile_issue_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .wb_err (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous read returning pre-write data.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      mem[3] <= 32'h11;
      mem[5] <= 32'h22;
    end else if (bus.rd_write) begin
      mem[bus.rd_addr] <= bus.rd_wdata;
    end
    if (bus.rs1_read) bus.rs1_rdata <= mem[bus.rs1_addr];
    if (bus.rs2_read) bus.rs2_rdata <= mem[bus.rs2_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input reg_addr_t rs1, input reg_addr_t rs2,
                       input reg_addr_t rd, input logic we);
    bus.iss_valid = v;
    bus.iss_rs1   = rs1;
    bus.iss_rs2   = rs2;
    bus.iss_rd    = rd;
    bus.iss_rd_we = we;
  endtask

  task automatic alu(input logic v, input reg_addr_t a, input xdata_t d);
    bus.alu_wb_valid = v;
    bus.alu_wb_addr  = a;
    bus.alu_wb_data  = d;
  endtask

  task automatic ld(input logic v, input reg_addr_t a, input xdata_t d);
    bus.ld_wb_valid = v;
    bus.ld_wb_addr  = a;
    bus.ld_wb_data  = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    alu(1'b0, 4'd0, 32'h0);
    ld(1'b0, 4'd0, 32'h0);
    bus.rs1_rdata = '0;
    bus.rs2_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_valid", 32'(bus.op_valid), 32'h0);
    check("rst_wb_err", 32'(wb_err), 32'h0);
    check("rst_op_rs1", bus.op_rs1_data, 32'h0);
    check("rst_op_rs2", bus.op_rs2_data, 32'h0);
    check("rst_rd_write", 32'(bus.rd_write), 32'h0);
    check("rst_ld_ready", 32'(bus.ld_wb_ready), 32'h1);
    @(negedge clk) rst = 1'b0;

    // Plain issue with operands from the register file
    @(negedge clk) issue(1'b1, 4'd3, 4'd5, 4'd7, 1'b1);
    #1;
    check("iss1_ready", 32'(bus.iss_ready), 32'h1);
    check("iss1_rs1_read", 32'(bus.rs1_read), 32'h1);
    check("iss1_rs1_addr", 32'(bus.rs1_addr), 32'h3);
    check("iss1_rs2_addr", 32'(bus.rs2_addr), 32'h5);
    after_edge();
    check("iss1_op_valid", 32'(bus.op_valid), 32'h1);
    check("iss1_op_rs1", bus.op_rs1_data, 32'h11);
    check("iss1_op_rs2", bus.op_rs2_data, 32'h22);
    check("iss1_busy", 32'(busy), 32'h80);

    // RAW stall on x7, then released by a same-cycle ALU writeback
    @(negedge clk) issue(1'b1, 4'd7, 4'd0, 4'd0, 1'b0);
    #1;
    check("raw_stall_ready", 32'(bus.iss_ready), 32'h0);
    after_edge();
    check("raw_stall_op_valid", 32'(bus.op_valid), 32'h0);
    check("raw_stall_busy", 32'(busy), 32'h80);
    @(negedge clk) alu(1'b1, 4'd7, 32'hDEAD);
    #1;
    check("raw_fwd_ready", 32'(bus.iss_ready), 32'h1);
    check("raw_fwd_rd_write", 32'(bus.rd_write), 32'h1);
    check("raw_fwd_rd_addr", 32'(bus.rd_addr), 32'h7);
    after_edge();
    check("raw_fwd_op_valid", 32'(bus.op_valid), 32'h1);
    check("raw_fwd_op_rs1", bus.op_rs1_data, 32'hDEAD);
    check("raw_fwd_op_rs2", bus.op_rs2_data, 32'h0);
    check("raw_fwd_busy", 32'(busy), 32'h0);

    // Make x4 and x6 pending, then collide ALU and load writebacks
    @(negedge clk) begin
      alu(1'b0, 4'd0, 32'h0);
      issue(1'b1, 4'd0, 4'd0, 4'd4, 1'b1);
    end
    @(negedge clk) issue(1'b1, 4'd0, 4'd0, 4'd6, 1'b1);
    after_edge();
    check("arb_busy_pre", 32'(busy), 32'h50);
    @(negedge clk) begin
      issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      alu(1'b1, 4'd4, 32'hA);
      ld(1'b1, 4'd6, 32'hB);
    end
    #1;
    check("arb_alu_rd_write", 32'(bus.rd_write), 32'h1);
    check("arb_alu_rd_addr", 32'(bus.rd_addr), 32'h4);
    check("arb_alu_rd_wdata", bus.rd_wdata, 32'hA);
    check("arb_ld_ready_low", 32'(bus.ld_wb_ready), 32'h0);
    after_edge();
    check("arb_busy_mid", 32'(busy), 32'h40);
    @(negedge clk) alu(1'b0, 4'd0, 32'h0);
    #1;
    check("arb_ld_ready_high", 32'(bus.ld_wb_ready), 32'h1);
    check("arb_ld_rd_write", 32'(bus.rd_write), 32'h1);
    check("arb_ld_rd_addr", 32'(bus.rd_addr), 32'h6);
    check("arb_ld_rd_wdata", bus.rd_wdata, 32'hB);
    after_edge();
    check("arb_busy_post", 32'(busy), 32'h0);
    check("arb_wb_err", 32'(wb_err), 32'h0);

    // x0 as source and destination; load writeback to x0
    @(negedge clk) begin
      ld(1'b0, 4'd0, 32'h0);
      issue(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    end
    #1;
    check("x0_ready", 32'(bus.iss_ready), 32'h1);
    after_edge();
    check("x0_op_valid", 32'(bus.op_valid), 32'h1);
    check("x0_op_rs1", bus.op_rs1_data, 32'h0);
    check("x0_busy", 32'(busy), 32'h0);
    @(negedge clk) begin
      issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      ld(1'b1, 4'd0, 32'h55);
    end
    #1;
    check("x0_ld_ready", 32'(bus.ld_wb_ready), 32'h1);
    check("x0_ld_rd_write", 32'(bus.rd_write), 32'h0);
    after_edge();
    check("x0_wb_err", 32'(wb_err), 32'h0);
    check("x0_op_valid_idle", 32'(bus.op_valid), 32'h0);

    // WAW on x9, then release-and-reissue in one cycle
    @(negedge clk) begin
      ld(1'b0, 4'd0, 32'h0);
      issue(1'b1, 4'd0, 4'd0, 4'd9, 1'b1);
    end
    @(negedge clk);
    #1;
    check("waw_stall_ready", 32'(bus.iss_ready), 32'h0);
    after_edge();
    check("waw_stall_op_valid", 32'(bus.op_valid), 32'h0);
    check("waw_stall_busy", 32'(busy), 32'h200);
    @(negedge clk) begin
      alu(1'b1, 4'd9, 32'h99);
      issue(1'b1, 4'd9, 4'd0, 4'd9, 1'b1);
    end
    #1;
    check("waw_rel_ready", 32'(bus.iss_ready), 32'h1);
    after_edge();
    check("waw_rel_busy", 32'(busy), 32'h200);
    check("waw_rel_op_valid", 32'(bus.op_valid), 32'h1);
    check("waw_rel_op_rs1", bus.op_rs1_data, 32'h99);

    // Writeback to a non-pending register sets a sticky error
    @(negedge clk) begin
      issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      alu(1'b1, 4'd12, 32'hC);
    end
    after_edge();
    check("err_set", 32'(wb_err), 32'h1);
    @(negedge clk) begin
      alu(1'b0, 4'd0, 32'h0);
      issue(1'b1, 4'd0, 4'd0, 4'd10, 1'b1);
    end
    after_edge();
    check("err_hold", 32'(wb_err), 32'h1);
    check("pre_rst_op_valid", 32'(bus.op_valid), 32'h1);
    check("pre_rst_busy", 32'(busy), 32'h600);

    // Asynchronous reset in the middle of a stall
    @(negedge clk) issue(1'b1, 4'd0, 4'd0, 4'd9, 1'b1);
    #1;
    check("mid_stall_ready", 32'(bus.iss_ready), 32'h0);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_op_valid", 32'(bus.op_valid), 32'h0);
    check("async_rst_wb_err", 32'(wb_err), 32'h0);
    @(negedge clk) begin
      issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
      rst = 1'b0;
    end
    after_edge();
    check("post_rst_op_valid", 32'(bus.op_valid), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
